stim_sequencer: RTL

STIM_SEQUENCER -- requirements
Module: stim_sequencer

---
 rtl/tb_gen_pkg.sv | 26 ++
 rtl/stim_sequencer_lfsr32.sv | 23 ++
 rtl/stim_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/tb_gen_pkg.sv
// Shared types and constants for the stimulus sequencer: FSM states and the
// Galois LFSR definition used for the pseudo-random stimulus phase.
package tb_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_RAND,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [31:0] LFSR_MASK    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

  // Right-shifting Galois step for x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] q);
    return {1'b0, q[31:1]} ^ (q[0] ? LFSR_MASK : 32'h0);
  endfunction

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/stim_sequencer_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and step enable.
module lfsr32
  import tb_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= seed_fix(seed);
    end else if (load) begin
      q <= seed_fix(seed);
    end else if (en) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/stim_sequencer.sv
// Stimulus sequencer: replays stored vectors with a one-cycle-latency response
// check, then issues LFSR stimulus, drains one cycle and reports done.
module stim_sequencer
  import tb_gen_pkg::*;
#(
  parameter int          VEC_W       = 15,
  parameter int          RESP_W      = 4,
  parameter int          DEPTH       = 10,
  parameter int          RAND_CYCLES = 30,
  parameter logic [31:0] SEED        = DEFAULT_SEED,
  localparam int         AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int         MW          = VEC_W + RESP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [MW-1:0]     load_data,
  input  logic              start,
  input  logic [RESP_W-1:0] resp_in,
  output logic [VEC_W-1:0]  stim_out,
  output logic              stim_valid,
  output logic              err_pulse,
  output logic [31:0]       vec_num,
  output logic [31:0]       err_cnt,
  output logic              busy,
  output logic              done
);

  localparam logic [AW:0]  DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [31:0]  RC      = 32'(RAND_CYCLES);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [MW-1:0]     mem [DEPTH];
  state_t            state;
  logic [AW:0]       ptr;
  logic [31:0]       rand_cnt;
  logic [RESP_W-1:0] exp_p0, exp_p1;
  logic              vld_p0, vld_p1;
  logic [31:0]       lfsr_q;
  logic [VEC_W-1:0]  rand_vec;
  logic              idle_like, play_last, lfsr_load, lfsr_en, mismatch;

  always_comb begin
    idle_like = (state == ST_IDLE) || (state == ST_DONE);
    play_last = (ptr == DEPTH_W);
    lfsr_load = idle_like && start;
    lfsr_en   = ((state == ST_PLAY) && play_last && (RC != 32'd0)) ||
                ((state == ST_RAND) && (rand_cnt != RC));
    rand_vec  = VEC_W'(lfsr_q);
    mismatch  = vld_p1 && (resp_in != exp_p1);
  end

  lfsr32 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .en   (lfsr_en),
    .seed (SEED),
    .q    (lfsr_q)
  );

  // Vector memory: written only while idle, never reset.
  always_ff @(posedge clk) begin
    if (load_en && idle_like && ({1'b0, load_addr} < DEPTH_W)) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      stim_out   <= '0;
      stim_valid <= 1'b0;
      err_pulse  <= 1'b0;
      vec_num    <= '0;
      err_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ptr        <= '0;
      rand_cnt   <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      // p1: expected value aligned with the cycle the response arrives
      vld_p1    <= vld_p0;
      exp_p1    <= exp_p0;
      vld_p0    <= 1'b0;
      // compare: response against the vector issued one cycle earlier
      err_pulse <= mismatch;
      if (mismatch) begin
        err_cnt <= sat_inc(err_cnt);
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_PLAY;
            busy       <= 1'b1;
            done       <= 1'b0;
            stim_out   <= mem[0][MW-1:RESP_W];
            exp_p0     <= mem[0][RESP_W-1:0];
            vld_p0     <= 1'b1;
            stim_valid <= 1'b1;
            ptr        <= (AW + 1)'(1);
            vec_num    <= 32'd1;
            err_cnt    <= '0;
            rand_cnt   <= '0;
          end
        end
        ST_PLAY: begin
          if (play_last) begin
            if (RC != 32'd0) begin
              state    <= ST_RAND;
              stim_out <= rand_vec;
              rand_cnt <= 32'd1;
              vec_num  <= vec_num + 32'd1;
            end else begin
              state      <= ST_DRAIN;
              stim_valid <= 1'b0;
            end
          end else begin
            stim_out <= mem[ptr[AW-1:0]][MW-1:RESP_W];
            exp_p0   <= mem[ptr[AW-1:0]][RESP_W-1:0];
            vld_p0   <= 1'b1;
            ptr      <= ptr + (AW + 1)'(1);
            vec_num  <= vec_num + 32'd1;
          end
        end
        ST_RAND: begin
          if (rand_cnt == RC) begin
            state      <= ST_DRAIN;
            stim_valid <= 1'b0;
          end else begin
            stim_out <= rand_vec;
            rand_cnt <= rand_cnt + 32'd1;
            vec_num  <= vec_num + 32'd1;
          end
        end
        ST_DRAIN: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
